// File: rtl/async_mram_ctrl.sv
// Asynchronous MRAM controller: turns single-beat read/write requests into
// glitch-free chip-enable / output-enable / write-enable / byte-lane strobes
// for an asynchronous MRAM. Phase lengths are set in clk cycles.
//
// Optional feature: define ASYNC_MRAM_CTRL_WRITE_VERIFY_EN to read back every
// write with nonzero byte enables and flag mismatching lanes on verify_err.
//
// Ports
//   clk, rstnn                      system clock, async active-low reset
//   req_valid/req_ready/req_write   request handshake (ready only in IDLE)
//   req_addr/req_wdata/req_byteen   request payload, byteen 1 = lane enabled
//   rsp_valid/rsp_write/rsp_rdata   one-cycle response pulse, read data
//   verify_err                      write-verify mismatch (with rsp_valid)
//   mem_*                           memory pins, all strobes active low
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// RD     | read access, E/G low for T_RD cycles
// WR_AS  | write address/data setup, E low, data driven
// WR_WP  | write pulse, W and enabled lanes low
// WR_WH  | write hold, W high, data still driven
// REC    | recovery, all strobes high; response pulses in its first cycle
// VFY    | read-back of a completed write (verify builds only)
module async_mram_ctrl #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 16,
    parameter int T_RD   = 4,
    parameter int T_AS   = 1,
    parameter int T_WP   = 3,
    parameter int T_WH   = 1,
    parameter int T_REC  = 1,
    localparam int NB    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rstnn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [NB-1:0]     req_byteen,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              verify_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dq_o,
    output logic              mem_dq_oe,
    input  logic [DATA_W-1:0] mem_dq_i,
    output logic              mem_e_b,
    output logic              mem_g_b,
    output logic              mem_w_b,
    output logic [NB-1:0]     mem_bl_b
);

    typedef enum logic [2:0] {
        IDLE, RD, WR_AS, WR_WP, WR_WH, REC
`ifdef ASYNC_MRAM_CTRL_WRITE_VERIFY_EN
        , VFY
`endif
    } state_t;

    localparam logic [7:0] LD_RD  = 8'(T_RD - 1);
    localparam logic [7:0] LD_AS  = 8'(T_AS - 1);
    localparam logic [7:0] LD_WP  = 8'(T_WP - 1);
    localparam logic [7:0] LD_WH  = 8'(T_WH - 1);
    localparam logic [7:0] LD_REC = 8'(T_REC - 1);

    state_t            state;
    logic [7:0]        cnt;
    logic              rdy;
    logic [NB-1:0]     a_byteen;
    logic [DATA_W-1:0] lane_mask;

    assign req_ready = rdy;

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < NB; i++) begin
            lane_mask[i*8 +: 8] = {8{a_byteen[i]}};
        end
    end

`ifdef ASYNC_MRAM_CTRL_WRITE_VERIFY_EN
    // Set while the post-write REC gap is a prelude to VFY rather than the
    // final recovery, so REC knows whether to start the read-back.
    logic vfy_pend;
`else
    assign verify_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state     <= IDLE;
            cnt       <= '0;
            rdy       <= 1'b0;
            a_byteen  <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            mem_addr  <= '0;
            mem_dq_o  <= '0;
            mem_dq_oe <= 1'b0;
            mem_e_b   <= 1'b1;
            mem_g_b   <= 1'b1;
            mem_w_b   <= 1'b1;
            mem_bl_b  <= '1;
`ifdef ASYNC_MRAM_CTRL_WRITE_VERIFY_EN
            vfy_pend   <= 1'b0;
            verify_err <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
`ifdef ASYNC_MRAM_CTRL_WRITE_VERIFY_EN
            verify_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_valid && rdy) begin
                        rdy      <= 1'b0;
                        a_byteen <= req_byteen;
                        mem_addr <= req_addr;
                        mem_e_b  <= 1'b0;
                        if (req_write) begin
                            state     <= WR_AS;
                            cnt       <= LD_AS;
                            mem_dq_o  <= req_wdata;
                            mem_dq_oe <= 1'b1;
                        end else begin
                            state    <= RD;
                            cnt      <= LD_RD;
                            mem_g_b  <= 1'b0;
                            mem_bl_b <= ~req_byteen;
                        end
                    end else begin
                        rdy <= 1'b1;
                    end
                end
                RD: begin
                    if (cnt == 8'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b0;
                        rsp_rdata <= mem_dq_i & lane_mask;
                        state     <= REC;
                        cnt       <= LD_REC;
                        mem_e_b   <= 1'b1;
                        mem_g_b   <= 1'b1;
                        mem_bl_b  <= '1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                WR_AS: begin
                    if (cnt == 8'd0) begin
                        state <= WR_WP;
                        cnt   <= LD_WP;
                        // All-zero byteen keeps full timing but never strobes.
                        if (|a_byteen) begin
                            mem_w_b  <= 1'b0;
                            mem_bl_b <= ~a_byteen;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                WR_WP: begin
                    if (cnt == 8'd0) begin
                        state    <= WR_WH;
                        cnt      <= LD_WH;
                        mem_w_b  <= 1'b1;
                        mem_bl_b <= '1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                WR_WH: begin
                    if (cnt == 8'd0) begin
                        state     <= REC;
                        cnt       <= LD_REC;
                        mem_e_b   <= 1'b1;
                        mem_dq_oe <= 1'b0;
`ifdef ASYNC_MRAM_CTRL_WRITE_VERIFY_EN
                        if (|a_byteen) begin
                            vfy_pend <= 1'b1;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_write <= 1'b1;
                        end
`else
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                REC: begin
                    if (cnt == 8'd0) begin
`ifdef ASYNC_MRAM_CTRL_WRITE_VERIFY_EN
                        if (vfy_pend) begin
                            vfy_pend <= 1'b0;
                            state    <= VFY;
                            cnt      <= LD_RD;
                            mem_e_b  <= 1'b0;
                            mem_g_b  <= 1'b0;
                            mem_bl_b <= ~a_byteen;
                        end else begin
                            state <= IDLE;
                            rdy   <= 1'b1;
                        end
`else
                        state <= IDLE;
                        rdy   <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
`ifdef ASYNC_MRAM_CTRL_WRITE_VERIFY_EN
                VFY: begin
                    if (cnt == 8'd0) begin
                        rsp_valid  <= 1'b1;
                        rsp_write  <= 1'b1;
                        verify_err <= |((mem_dq_i ^ mem_dq_o) & lane_mask);
                        state      <= REC;
                        cnt        <= LD_REC;
                        mem_e_b    <= 1'b1;
                        mem_g_b    <= 1'b1;
                        mem_bl_b   <= '1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_async_mram_ctrl.sv
// Directed bench for async_mram_ctrl with default parameters.
module tb_async_mram_ctrl;

    logic        clk = 1'b0;
    logic        rstnn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [20:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_byteen = '0;
    logic        rsp_valid;
    logic        rsp_write;
    logic [15:0] rsp_rdata;
    logic        verify_err;
    logic [20:0] mem_addr;
    logic [15:0] mem_dq_o;
    logic        mem_dq_oe;
    logic [15:0] mem_dq_i;
    logic        mem_e_b;
    logic        mem_g_b;
    logic        mem_w_b;
    logic [1:0]  mem_bl_b;

    logic [15:0] rd_data = 16'h0000;
    assign mem_dq_i = rd_data;

`ifdef ASYNC_MRAM_CTRL_WRITE_VERIFY_EN
    localparam int WR_RSP = 11;
`else
    localparam int WR_RSP = 6;
`endif

    async_mram_ctrl dut (
        .clk(clk), .rstnn(rstnn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_byteen(req_byteen),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .verify_err(verify_err),
        .mem_addr(mem_addr), .mem_dq_o(mem_dq_o), .mem_dq_oe(mem_dq_oe),
        .mem_dq_i(mem_dq_i), .mem_e_b(mem_e_b), .mem_g_b(mem_g_b),
        .mem_w_b(mem_w_b), .mem_bl_b(mem_bl_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Whole-run monitors for properties that must hold at every cycle.
    int oe_g_ovl = 0;
    int verr_hi  = 0;
    always @(negedge clk) begin
        if (mem_dq_oe && !mem_g_b) oe_g_ovl++;
        if (verify_err && !rsp_valid) verr_hi++;
    end

    // Per-access statistics, cycle c = 1 is the cycle right after accept.
    int          e_low, g_low, w_low, oe_cyc, rsp_cyc, rsp_cnt;
    int          bl_bad, addr_bad, dq_bad;
    logic [15:0] rdata_at;
    logic        rw_at, err_at;

    task automatic sample(input int c, input logic [20:0] a, input logic [15:0] d,
                          input logic [1:0] be);
        if (!mem_e_b) begin
            e_low++;
            if (mem_addr !== a) addr_bad++;
        end
        if (!mem_g_b) begin
            g_low++;
            if (mem_bl_b !== ~be) bl_bad++;
        end
        if (!mem_w_b) begin
            w_low++;
            if (mem_bl_b !== ~be) bl_bad++;
        end
        if (mem_dq_oe) begin
            oe_cyc++;
            if (mem_dq_o !== d) dq_bad++;
            if (mem_addr !== a) addr_bad++;
            if (mem_w_b && mem_bl_b !== 2'b11) bl_bad++;
        end
        if (rsp_valid) begin
            rsp_cnt++;
            if (rsp_cyc == 0) begin
                rsp_cyc  = c;
                rdata_at = rsp_rdata;
                rw_at    = rsp_write;
                err_at   = verify_err;
            end
        end
    endtask

    task automatic access(input logic wr, input logic [20:0] a, input logic [15:0] d,
                          input logic [1:0] be, input int ncyc);
        int waited = 0;
        e_low = 0; g_low = 0; w_low = 0; oe_cyc = 0; rsp_cyc = 0; rsp_cnt = 0;
        bl_bad = 0; addr_bad = 0; dq_bad = 0; rdata_at = '0; rw_at = 0; err_at = 0;
        @(negedge clk);
        while (!req_ready && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) chk("ready_timeout", 0, 1);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_byteen = be;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        sample(1, a, d, be);
        for (int c = 2; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            sample(c, a, d, be);
        end
    endtask

    int acc [2];
    int n_acc, lowc, ehigh, rsp_seen;

    initial begin
        // Reset state
        #12;
        chk("rst_ready", req_ready, 0);
        chk("rst_e", mem_e_b, 1);
        chk("rst_g", mem_g_b, 1);
        chk("rst_w", mem_w_b, 1);
        chk("rst_bl", mem_bl_b, 2'b11);
        chk("rst_oe", mem_dq_oe, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_dq", mem_dq_o, 0);
        chk("rst_rsp", {rsp_valid, rsp_write}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_verr", verify_err, 0);
        @(negedge clk);
        rstnn = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", req_ready, 1);

        // Full-width read
        rd_data = 16'hA55A;
        access(1'b0, 21'h00010, 16'h0, 2'b11, 8);
        chk("rd_e_low", e_low, 4);
        chk("rd_g_low", g_low, 4);
        chk("rd_w_low", w_low, 0);
        chk("rd_rsp_cyc", rsp_cyc, 5);
        chk("rd_rsp_cnt", rsp_cnt, 1);
        chk("rd_rdata", rdata_at, 16'hA55A);
        chk("rd_rsp_write", rw_at, 0);
        chk("rd_addr_bad", addr_bad, 0);
        chk("rd_bl_bad", bl_bad, 0);

        // Single-lane read masks the disabled lane to zero
        rd_data = 16'hC33C;
        access(1'b0, 21'h0ABCD, 16'h0, 2'b01, 8);
        chk("rd01_rdata", rdata_at, 16'h003C);
        chk("rd01_bl_bad", bl_bad, 0);
        chk("rd01_rsp_cyc", rsp_cyc, 5);

        // Low-lane write at the top address
        rd_data = 16'h1234;
        access(1'b1, 21'h1FFFFF, 16'h1234, 2'b01, 13);
        chk("wr_w_low", w_low, 3);
        chk("wr_g_low", g_low, (WR_RSP == 6) ? 0 : 4);
        chk("wr_bl_bad", bl_bad, 0);
        chk("wr_oe_cyc", oe_cyc, 5);
        chk("wr_addr_bad", addr_bad, 0);
        chk("wr_dq_bad", dq_bad, 0);
        chk("wr_rsp_cyc", rsp_cyc, WR_RSP);
        chk("wr_rsp_write", rw_at, 1);
        chk("wr_rsp_cnt", rsp_cnt, 1);

        // Write with no lanes enabled: same timing, no strobe
        access(1'b1, 21'h00100, 16'hBEEF, 2'b00, 10);
        chk("wr00_w_low", w_low, 0);
        chk("wr00_oe_cyc", oe_cyc, 5);
        chk("wr00_rsp_cyc", rsp_cyc, 6);
        chk("wr00_rsp_write", rw_at, 1);

        // Back-to-back reads with req_valid held high
        @(negedge clk);
        req_write = 1'b0; req_addr = 21'h00020; req_byteen = 2'b11;
        req_valid = 1'b1;
        n_acc = 0; lowc = 0; ehigh = 0;
        for (int k = 0; k < 40 && n_acc < 2; k++) begin
            @(negedge clk);
            if (n_acc == 1 && mem_e_b) ehigh++;
            if (req_ready) begin
                acc[n_acc] = k;
                n_acc++;
            end else if (n_acc == 1) begin
                lowc++;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("b2b_accepts", n_acc, 2);
        chk("b2b_spacing", acc[1] - acc[0], 6);
        chk("b2b_ready_low", lowc, 5);
        chk("b2b_e_gap", ehigh, 2);
        repeat (8) @(posedge clk);

        // Reset during the second write-pulse cycle
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 21'h00055;
        req_wdata = 16'h5555; req_byteen = 2'b11;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rstmid_in_wp", mem_w_b, 0);
        #2;
        rstnn = 1'b0;
        #1;
        chk("rstmid_w", mem_w_b, 1);
        chk("rstmid_e", mem_e_b, 1);
        chk("rstmid_oe", mem_dq_oe, 0);
        chk("rstmid_ready", req_ready, 0);
        rsp_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        rstnn = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        chk("rstmid_no_rsp", rsp_seen, 0);

        rd_data = 16'h0F0F;
        access(1'b0, 21'h00033, 16'h0, 2'b10, 8);
        chk("post_rst_rsp_cyc", rsp_cyc, 5);
        chk("post_rst_rdata", rdata_at, 16'h0F00);

`ifdef ASYNC_MRAM_CTRL_WRITE_VERIFY_EN
        rd_data = 16'h1230;
        access(1'b1, 21'h00777, 16'h1234, 2'b11, 13);
        chk("vfy_bad_rsp_cyc", rsp_cyc, 11);
        chk("vfy_bad_err", err_at, 1);
        rd_data = 16'h1234;
        access(1'b1, 21'h00777, 16'h1234, 2'b11, 13);
        chk("vfy_ok_rsp_cyc", rsp_cyc, 11);
        chk("vfy_ok_err", err_at, 0);
`endif

        chk("oe_while_g_low", oe_g_ovl, 0);
        chk("verr_without_rsp", verr_hi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
